// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between execute and DMem.
// Takes one byte/half/word request at a time, drives lane-aligned address, data
// and byte mask to DMem, then extracts and extends load data for a one-cycle
// response. Build option: LSU_MISALIGN_SPLIT_EN splits misaligned half/word
// accesses into two word accesses; without it such accesses return rsp_err.
// DMem read data arrives one cycle after the address, so rsp_rdata is formed
// combinationally from MemReadData during the response cycle.

module dmem_lsu #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemWriteData,
    output logic [3:0]        MemWriteMask,
    input  logic [31:0]       MemReadData
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e              state_q, state_d;

    // Captured request fields
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   w0data_q, w0data_d;

    // Registered outputs
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   mwdata_q, mwdata_d;
    logic [MASK_W-1:0]   mmask_q, mmask_d;

    // Lane decode inputs: live request while idle, captured fields otherwise
    logic                sel_we;
    logic [1:0]          sel_size;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    logic [MASK_W-1:0]   base_mask;
    logic [2*MASK_W-1:0] lane_mask;
    logic [2*DATA_W-1:0] lane_data;
    logic                need_split;
    logic                acc_err;
    logic                acc_split;
    logic                do_write;
    logic [ADDR_W-1:0]   word0;
    logic [ADDR_W-1:0]   word1;

    logic [DATA_W-1:0]   rd_w0;
    logic [DATA_W-1:0]   rd_w1;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rd_ext;

    // Select which request fields feed the lane decode
    always_comb begin
        sel_we    = we_q;
        sel_size  = size_q;
        sel_addr  = addr_q;
        sel_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            sel_we    = req_we;
            sel_size  = req_size;
            sel_addr  = req_addr;
            sel_wdata = req_wdata;
        end
    end

    // Byte-lane placement, split detection and error classification
    always_comb begin
        unique case (sel_size)
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            2'b10:   base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
        lane_mask  = 8'(base_mask) << sel_addr[1:0];
        lane_data  = 64'(sel_wdata) << {sel_addr[1:0], 3'b000};
        need_split = |lane_mask[7:4];
        acc_err    = (sel_size == 2'b11) || (!SPLIT_EN && need_split);
        acc_split  = SPLIT_EN && need_split;
        do_write   = sel_we && !acc_err;
        word0      = {sel_addr[ADDR_W-1:2], 2'b00};
        word1      = word0 + ADDR_W'(4);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        w0data_d = w0data_q;
        ready_d  = 1'b0;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        maddr_d  = maddr_q;
        mwdata_d = '0;
        mmask_d  = '0;

        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (req_valid) begin
                    state_d = S_ACC0;
                    ready_d = 1'b0;
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    maddr_d = word0;
                    if (do_write) begin
                        mmask_d  = lane_mask[3:0];
                        mwdata_d = lane_data[31:0];
                    end
                end
            end
            S_ACC0: begin
                if (acc_split) begin
                    state_d = S_ACC1;
                    maddr_d = word1;
                    if (do_write) begin
                        mmask_d  = lane_mask[7:4];
                        mwdata_d = lane_data[63:32];
                    end
                end else begin
                    state_d = S_RESP;
                    valid_d = 1'b1;
                    err_d   = acc_err;
                end
            end
            S_ACC1: begin
                state_d  = S_RESP;
                valid_d  = 1'b1;
                err_d    = acc_err;
                w0data_d = MemReadData;
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            w0data_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            w0data_q <= w0data_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mmask_q  <= mmask_d;
        end
    end

    // Load extraction: shift the word pair down by the byte offset, then extend
    always_comb begin
        rd_w0   = acc_split ? w0data_q : MemReadData;
        rd_w1   = acc_split ? MemReadData : '0;
        rd_word = 32'({rd_w1, rd_w0} >> {addr_q[1:0], 3'b000});
        unique case (size_q)
            2'b00:   rd_ext = uns_q ? {24'h000000, rd_word[7:0]}
                                    : {{24{rd_word[7]}}, rd_word[7:0]};
            2'b01:   rd_ext = uns_q ? {16'h0000, rd_word[15:0]}
                                    : {{16{rd_word[15]}}, rd_word[15:0]};
            2'b10:   rd_ext = rd_word;
            default: rd_ext = '0;
        endcase
        rsp_rdata = (valid_q && !err_q && !we_q) ? rd_ext : '0;
    end

    assign req_ready    = ready_q;
    assign rsp_valid    = valid_q;
    assign rsp_err      = err_q;
    assign MemAddress   = maddr_q;
    assign MemWriteData = mwdata_q;
    assign MemWriteMask = mmask_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu with a synchronous-read DMem model.
// Reference model is byte-addressed memory plus plain size/offset arithmetic.

module tb_dmem_lsu;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  MemAddress;
    logic [31:0] MemWriteData;
    logic [3:0]  MemWriteMask;
    logic [31:0] MemReadData;

    dmem_lsu #(.ADDR_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWriteMask (MemWriteMask),
        .MemReadData  (MemReadData)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } rsp_t;

    typedef struct {
        logic [9:0]  addr;
        logic [3:0]  mask;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    logic [7:0]  ref_mem [1024];
    logic [31:0] dmem [256];
    int unsigned cyc;
    int          n_cmp;
    int          n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // DMem: synchronous read of the presented word, byte-masked write
    always @(posedge clk) begin
        MemReadData <= dmem[MemAddress[9:2]];
        for (int b = 0; b < 4; b++)
            if (MemWriteMask[b]) dmem[MemAddress[9:2]][8*b +: 8] <= MemWriteData[8*b +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a response or a write
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b expected none", rsp_rdata, rsp_err);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    chk("rsp_cycle", cyc, r.cyc);
                end
            end
            if (MemWriteMask != 4'b0000) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got addr %h mask %b data %h expected none",
                             MemAddress, MemWriteMask, MemWriteData);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(MemAddress), 32'(w.addr));
                    chk("wr_mask", 32'(MemWriteMask), 32'(w.mask));
                    chk("wr_data", MemWriteData, w.data);
                    chk("wr_cycle", cyc, w.cyc);
                end
            end else if (MemWriteData != 32'h0) begin
                n_cmp++; n_bad++;
                $display("FAIL wdata_without_mask: got %h expected 00000000", MemWriteData);
            end
        end
    end

    // Reference model: byte-granular memory, expectations queued at acceptance
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata,
                         input int unsigned now, input bit expect_rsp);
        int          nb;
        int          off;
        bit          err;
        bit          mis;
        logic [63:0] d64;
        logic [7:0]  m8;
        logic [9:0]  w0;
        logic [31:0] v;
        rsp_t        r;
        wr_t         w;
        off = int'(addr[1:0]);
        case (size)
            2'b00:   nb = 1;
            2'b01:   nb = 2;
            2'b10:   nb = 4;
            default: nb = 0;
        endcase
        mis = (off + nb) > 4;
        err = (size == 2'b11) || (mis && !SPLIT_EN);
        w0  = {addr[9:2], 2'b00};
        if (we && !err) begin
            m8  = 8'h00;
            d64 = {32'h0, wdata};
            d64 = d64 << (8 * off);
            for (int i = 0; i < nb; i++) begin
                m8[off + i] = 1'b1;
                ref_mem[(int'(addr) + i) % 1024] = wdata[8*i +: 8];
            end
            w = '{addr: w0, mask: m8[3:0], data: d64[31:0], cyc: now + 1};
            wr_q.push_back(w);
            if (m8[7:4] != 4'b0000) begin
                w = '{addr: w0 + 10'd4, mask: m8[7:4], data: d64[63:32], cyc: now + 2};
                wr_q.push_back(w);
            end
        end
        v = 32'h0;
        if (!we && !err) begin
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) % 1024];
            if (nb < 4 && !uns && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        if (expect_rsp) begin
            r = '{rdata: v, err: err, cyc: now + 2 + ((!err && mis) ? 1 : 0)};
            rsp_q.push_back(r);
        end
    endtask

    // Wait for ready (driving ignored junk meanwhile), present the request for one edge
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata, input bit expect_rsp);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready) begin
            if (guard >= 20) begin
                n_cmp++; n_bad++;
                $display("FAIL ready_timeout: got req_ready 0 expected 1 within 20 cycles");
                return;
            end
            req_valid    = 1'($urandom_range(0, 1));
            req_we       = 1'($urandom_range(0, 1));
            req_size     = 2'($urandom_range(0, 3));
            req_unsigned = 1'($urandom_range(0, 1));
            req_addr     = 10'($urandom);
            req_wdata    = $urandom;
            guard++;
            @(negedge clk);
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        model(we, size, uns, addr, wdata, cyc, expect_rsp);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, "_mem_addr"}, 32'(MemAddress), 32'h0);
        chk({tag, "_mem_wdata"}, MemWriteData, 32'h0);
        chk({tag, "_mem_mask"}, 32'(MemWriteMask), 32'h0);
    endtask

    initial begin
        int guard;
        int bad_words;
        logic [31:0] rw;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 10'h0; req_wdata = 32'h0;
        for (int wi = 0; wi < 256; wi++) begin
            rw = $urandom;
            dmem[wi] = rw;
            for (int b = 0; b < 4; b++) ref_mem[4*wi + b] = rw[8*b +: 8];
        end
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;

        // Directed sequence from the test plan
        issue(1'b1, 2'b10, 1'b0, 10'h004, 32'h12345678, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 10'h004, 32'h0, 1'b1);
        issue(1'b1, 2'b00, 1'b0, 10'h006, 32'h000000AB, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 10'h006, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 10'h006, 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 10'h004, 32'h0, 1'b1);
        issue(1'b1, 2'b01, 1'b0, 10'h002, 32'h0000BEEF, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 10'h002, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 10'h002, 32'h0, 1'b1);
        issue(1'b1, 2'b10, 1'b0, 10'h00A, 32'hCAFEF00D, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 10'h00A, 32'h0, 1'b1);
        issue(1'b1, 2'b10, 1'b0, 10'h3FE, 32'h11223344, 1'b1);
        issue(1'b0, 2'b10, 1'b1, 10'h3FE, 32'h0, 1'b1);
        issue(1'b1, 2'b11, 1'b0, 10'h010, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 10'h003, 32'h0, 1'b1);
        issue(1'b1, 2'b01, 1'b0, 10'h3FF, 32'h0000A55A, 1'b1);
        idle(3);

        // Reset during ACC0 of a load: abort, no response
        issue(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_hold_rsp_valid", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", 32'(req_ready), 32'h1);

        // Randomized traffic, biased to a small region so stores and loads collide
        for (int k = 0; k < 400; k++) begin
            logic        we;
            logic [1:0]  sz;
            logic [9:0]  a;
            we = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 31)) : 10'($urandom);
            if ($urandom_range(0, 15) == 0) a = 10'h3FC + 10'($urandom_range(0, 3));
            issue(we, sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
            if (we && $urandom_range(0, 2) == 0)
                issue(1'b0, sz, 1'($urandom_range(0, 1)), a, 32'h0, 1'b1);
            if ($urandom_range(0, 7) == 0) idle(2);
        end

        idle(1);
        guard = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_rsp_pending", 32'(rsp_q.size()), 32'h0);
        chk("drain_wr_pending", 32'(wr_q.size()), 32'h0);

        bad_words = 0;
        for (int wi = 0; wi < 256; wi++) begin
            rw = {ref_mem[4*wi + 3], ref_mem[4*wi + 2], ref_mem[4*wi + 1], ref_mem[4*wi]};
            if (dmem[wi] !== rw) bad_words++;
        end
        chk("mem_final_bad_words", 32'(bad_words), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
